// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared encodings for the MIPS-32 multi-cycle control unit:
//               opcodes, FSM states, datapath select codes and trap causes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package mips_ctrl_pkg;

    // Supported primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Control FSM states; encodings are visible on the debug port
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RT      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_ITYPE = 2'd3;

    // Register file destination select
    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    // Register file write-data select
    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;

    // Reason the FSM entered TRAP
    typedef enum logic {
        CAUSE_ILLEGAL = 1'b0,
        CAUSE_TIMEOUT = 1'b1
    } trap_cause_t;

    // States that hold a memory request open until mem_ready
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_timer.sv
// ============================================================================
// Module      : mips_mem_wait_timer
// Description : Memory wait counter shared by every wait state. Cleared while
//               no request is waiting, advances on each unanswered cycle and
//               flags expiry on the last permitted waiting cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mips_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Wait-cycle counter; clear takes priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    assign expire = count_en && (count == LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multi-cycle control FSM for the MIPS-32 core. Sequences
//               fetch/decode/execute/memory/writeback over a shared ALU and a
//               single memory port. Optional macro MIPS_CTRL_PERF_CNT_EN adds
//               cycle and instruction counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_src,
    output logic        illegal_op,
    output logic        mem_timeout,
`ifdef MIPS_CTRL_PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt,
`endif
    output logic [3:0]  state_o
);

    state_t      state;
    state_t      state_next;
    trap_cause_t cause;
    logic        in_wait;
    logic        expire;

    // funct is decoded by the ALU control, not by this FSM
    logic unused_funct;
    assign unused_funct = ^funct;

    assign in_wait = is_wait_state(state);
    assign state_o = state;

    mips_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!in_wait || mem_ready),
        .count_en (in_wait && !mem_ready),
        .expire   (expire)
    );

    // Next-state selection; a ready memory beats an expiring timer
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = mem_ready ? S_DECODE : (expire ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                                state_next = S_R_EXEC;
                    OP_LW, OP_SW:                            state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                          state_next = S_BRANCH;
                    OP_J, OP_JAL:                            state_next = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_next = S_I_EXEC;
                    default:                                 state_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_next = mem_ready ? S_MEM_WB : (expire ? S_TRAP : S_MEM_RD);
            S_MEM_WR:   state_next = mem_ready ? S_FETCH : (expire ? S_TRAP : S_MEM_WR);
            S_R_EXEC:   state_next = S_R_WB;
            S_I_EXEC:   state_next = S_I_WB;
            default:    state_next = S_FETCH;
        endcase
    end

    // State register and trap cause capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cause <= CAUSE_ILLEGAL;
        end else begin
            state <= state_next;
            if (state == S_DECODE && state_next == S_TRAP) begin
                cause <= CAUSE_ILLEGAL;
            end else if (expire) begin
                cause <= CAUSE_TIMEOUT;
            end
        end
    end

    // Datapath controls decoded from state; everything forced low in reset
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_RT;
        alu_op      = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = REG_DST_RT;
        wd_src      = WD_ALUOUT;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRC_B_IMM_SH2;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = REG_DST_RT;
                    wd_src    = WD_MDR;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_RT;
                    alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = REG_DST_RD;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ITYPE;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = REG_DST_RT;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_RT;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_SRC_ALUOUT;
                    pc_write  = (opcode == OP_BNE) ? !alu_zero : alu_zero;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                    if (opcode == OP_JAL) begin
                        reg_write = 1'b1;
                        reg_dst   = REG_DST_R31;
                        wd_src    = WD_PC;
                    end
                end
                S_TRAP: begin
                    illegal_op  = (cause == CAUSE_ILLEGAL);
                    mem_timeout = (cause == CAUSE_TIMEOUT);
                end
                default: ;
            endcase
        end
    end

`ifdef MIPS_CTRL_PERF_CNT_EN
    // Free-running cycle count and completed-instruction count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state_next == S_FETCH && state != S_FETCH && state != S_TRAP) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Scoreboard bench for the multi-cycle control FSM. An
//               instruction-level model queues the expected control word for
//               every cycle; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wd_src;
        logic       illegal_op;
        logic       mem_timeout;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        reg_write;
    logic [1:0]  reg_dst, wd_src;
    logic        illegal_op, mem_timeout;
    logic [3:0]  state_o;

    ctl_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .alu_zero    (alu_zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .wd_src      (wd_src),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    function automatic ctl_t actual();
        ctl_t a;
        a.st = state_o;       a.mem_req = mem_req;     a.mem_we = mem_we;
        a.iord = iord;        a.ir_write = ir_write;   a.pc_write = pc_write;
        a.pc_src = pc_src;    a.src_a = alu_src_a;     a.src_b = alu_src_b;
        a.alu_op = alu_op;    a.reg_write = reg_write; a.reg_dst = reg_dst;
        a.wd_src = wd_src;    a.illegal_op = illegal_op;
        a.mem_timeout = mem_timeout;
        return a;
    endfunction

    function automatic ctl_t mk(input logic [3:0] s);
        ctl_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                          6'b000010, 6'b000011, 6'b001000, 6'b001010, 6'b001100,
                          6'b001101, 6'b001111};
    endfunction

    // Monitor: every cycle out of reset the DUT presents one control word
    always @(negedge clk) begin
        ctl_t e, a;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual();
            nvec++;
            if (a !== e) begin
                nerr++;
                $display("FAIL ctl_word t=%0t: actual %h required %h (state %0d vs %0d)",
                         $time, a, e, a.st, e.st);
            end
        end
    end

    // One clock of stimulus with the control word the model expects for it
    task automatic step(input ctl_t e, input logic rdy, input logic az);
        mem_ready = rdy;
        alu_zero  = az;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Memory wait: ready arrives after w unanswered cycles; 15 unanswered -> timeout
    task automatic wait_phase(input logic [3:0] st, input logic we, input logic io,
                              input bit fetch, input int w, output bit ok);
        ctl_t e;
        logic rdy;
        ok = 1'b0;
        for (int i = 0; i < 15; i++) begin
            e = mk(st);
            e.mem_req = 1'b1;
            e.mem_we  = we;
            e.iord    = io;
            rdy = (i == w);
            if (fetch) begin
                e.src_b    = 2'd1;
                e.ir_write = rdy;
                e.pc_write = rdy;
            end
            step(e, rdy, 1'($urandom));
            if (rdy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic trap_timeout();
        ctl_t e;
        e = mk(4'd12);
        e.mem_timeout = 1'b1;
        step(e, 1'($urandom), 1'($urandom));
    endtask

    // Instruction-level reference: expected cycle sequence of one instruction
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic az);
        ctl_t e;
        bit   ok;
        opcode = op;
        funct  = 6'($urandom);
        wait_phase(4'd0, 1'b0, 1'b0, 1'b1, fw, ok);
        if (!ok) begin
            trap_timeout();
            return;
        end
        e = mk(4'd1); e.src_b = 2'd3;
        step(e, 1'($urandom), 1'($urandom));
        if (op == 6'b000000) begin
            e = mk(4'd6); e.src_a = 1'b1; e.alu_op = 2'd2;
            step(e, 1'($urandom), 1'($urandom));
            e = mk(4'd7); e.reg_write = 1'b1; e.reg_dst = 2'd1;
            step(e, 1'($urandom), 1'($urandom));
        end else if (op inside {6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001111}) begin
            e = mk(4'd8); e.src_a = 1'b1; e.src_b = 2'd2; e.alu_op = 2'd3;
            step(e, 1'($urandom), 1'($urandom));
            e = mk(4'd9); e.reg_write = 1'b1;
            step(e, 1'($urandom), 1'($urandom));
        end else if (op == 6'b100011 || op == 6'b101011) begin
            e = mk(4'd2); e.src_a = 1'b1; e.src_b = 2'd2;
            step(e, 1'($urandom), 1'($urandom));
            if (op == 6'b100011) begin
                wait_phase(4'd3, 1'b0, 1'b1, 1'b0, mw, ok);
                if (ok) begin
                    e = mk(4'd4); e.reg_write = 1'b1; e.wd_src = 2'd1;
                    step(e, 1'($urandom), 1'($urandom));
                end else begin
                    trap_timeout();
                end
            end else begin
                wait_phase(4'd5, 1'b1, 1'b1, 1'b0, mw, ok);
                if (!ok) trap_timeout();
            end
        end else if (op == 6'b000100 || op == 6'b000101) begin
            e = mk(4'd10); e.src_a = 1'b1; e.alu_op = 2'd1; e.pc_src = 2'd1;
            e.pc_write = (op == 6'b000100) ? az : !az;
            step(e, 1'($urandom), az);
        end else if (op == 6'b000010 || op == 6'b000011) begin
            e = mk(4'd11); e.pc_write = 1'b1; e.pc_src = 2'd2;
            if (op == 6'b000011) begin
                e.reg_write = 1'b1; e.reg_dst = 2'd2; e.wd_src = 2'd2;
            end
            step(e, 1'($urandom), 1'($urandom));
        end else begin
            e = mk(4'd12); e.illegal_op = 1'b1;
            step(e, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic check_in_reset();
        nvec++;
        if (actual() !== ctl_t'('0)) begin
            nerr++;
            $display("FAIL reset_outputs: actual %h required %h", actual(), ctl_t'('0));
        end
        nvec++;
        if (mem_req !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mem_req: actual %b required 0", mem_req);
        end
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 3));
        return int'($urandom_range(12, 17));
    endfunction

    logic [5:0] ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                             6'b000011, 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001111};

    initial begin
        ctl_t e;
        logic [5:0] op;
        repeat (3) @(posedge clk);
        #1;
        check_in_reset();
        rst_n = 1'b1;
        // Partial fetch wait, then reset asserted mid-cycle while mem_req is high
        e = mk(4'd0); e.mem_req = 1'b1; e.src_b = 2'd1;
        for (int i = 0; i < 6; i++) step(e, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #2;
        nvec++;
        if (mem_req !== 1'b1) begin
            nerr++;
            $display("FAIL pre_reset_mem_req: actual %b required 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        check_in_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Ready on the 15th fetch cycle: counter restarted from zero after reset
        run_instr(6'b000000, 14, 0, 1'b0);
        // Directed cases
        run_instr(6'b000000, 0, 0, 1'b0);   // add
        run_instr(6'b100011, 0, 3, 1'b0);   // lw, 3 wait cycles
        run_instr(6'b000100, 0, 0, 1'b0);   // beq not taken
        run_instr(6'b000101, 0, 0, 1'b0);   // bne taken
        run_instr(6'b000100, 1, 0, 1'b1);   // beq taken
        run_instr(6'b000101, 0, 0, 1'b1);   // bne not taken
        run_instr(6'b111111, 0, 0, 1'b0);   // illegal
        run_instr(6'b000000, 20, 0, 1'b0);  // fetch timeout
        run_instr(6'b000000, 14, 0, 1'b0);  // ready exactly on last fetch cycle
        run_instr(6'b100011, 0, 20, 1'b0);  // lw timeout
        run_instr(6'b101011, 2, 14, 1'b0);  // sw ready on last cycle
        run_instr(6'b101011, 0, 20, 1'b0);  // sw timeout
        run_instr(6'b000010, 0, 0, 1'b0);   // j
        run_instr(6'b000011, 0, 0, 1'b0);   // jal
        run_instr(6'b001111, 0, 0, 1'b0);   // lui
        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                if (is_legal(op)) op = 6'b110011;
            end else begin
                op = ops[$urandom_range(0, 11)];
            end
            run_instr(op, pick_wait(), pick_wait(), 1'($urandom));
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            nerr++;
            $display("FAIL drain: actual %0d entries pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
